branch_tracker: RTL and testbench

- In-flight branch bookkeeping on the commit side of the branch predictor interface.
- Records each predicted branch from fetch in order and accepts out-of-order resolutions from the branch ALU.
- Retires branches in program order and drives the predictor update port (ROB_valid, commit_pc, real_result).
- On a mispredicted retirement, issues a one-cycle flush with the corrected fetch PC.

---
 rtl/branch_tracker_pkg.sv | 15 +
 rtl/branch_tracker_ram.sv | 38 +++
 rtl/branch_tracker.sv | 135 +++++++++++++
 tb/tb_branch_tracker.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_tracker_pkg.sv
// Shared constants for the branch tracker and the predictor it updates.
// real_result polarity: the predictor counts up on REAL_TAKEN.
package branch_tracker_pkg;

   localparam int DEPTH_DEFAULT = 8;
   localparam int TAG_W_DEFAULT = $clog2(DEPTH_DEFAULT);

   localparam logic REAL_TAKEN     = 1'b0;
   localparam logic REAL_NOT_TAKEN = 1'b1;

   function automatic logic real_result_of(input logic taken);
      return taken ? REAL_TAKEN : REAL_NOT_TAKEN;
   endfunction

endpackage

// File: rtl/branch_tracker_ram.sv
// Payload storage for in-flight branches: one write port at the tail,
// one combinational read port at the head. Status bits live in the top.
module branch_tracker_ram
   import branch_tracker_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEFAULT,
   parameter int TAG_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [TAG_W-1:0] waddr,
   input  logic [31:0]      wpc,
   input  logic             wpred,
   input  logic [31:0]      walt_pc,
   input  logic [TAG_W-1:0] raddr,
   output logic [31:0]      rpc,
   output logic             rpred,
   output logic [31:0]      ralt_pc
);

   logic [31:0] pc_mem     [DEPTH];
   logic        pred_mem   [DEPTH];
   logic [31:0] alt_pc_mem [DEPTH];

   // Payload needs no reset: an entry is only read once its valid bit is set.
   always_ff @(posedge clk) begin
      if (we) begin
         pc_mem[waddr]     <= wpc;
         pred_mem[waddr]   <= wpred;
         alt_pc_mem[waddr] <= walt_pc;
      end
   end

   assign rpc     = pc_mem[raddr];
   assign rpred   = pred_mem[raddr];
   assign ralt_pc = alt_pc_mem[raddr];

endmodule

// File: rtl/branch_tracker.sv
// In-flight branch bookkeeping: in-order allocate, out-of-order resolve,
// in-order retire with predictor update and one-cycle mispredict flush.
module branch_tracker
   import branch_tracker_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEFAULT,
   parameter int TAG_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rdy,
   input  logic             alloc_valid,
   input  logic [31:0]      alloc_pc,
   input  logic             alloc_pred,
   input  logic [31:0]      alloc_alt_pc,
   output logic [TAG_W-1:0] alloc_tag,
   output logic             full,
   input  logic             res_valid,
   input  logic [TAG_W-1:0] res_tag,
   input  logic             res_taken,
   output logic             ROB_valid,
   output logic [31:0]      commit_pc,
   output logic             real_result,
   output logic             flush,
   output logic [31:0]      flush_pc
);

   localparam logic [TAG_W:0] FULL_COUNT = (TAG_W+1)'(DEPTH);

   logic [TAG_W-1:0] head;
   logic [TAG_W-1:0] tail;
   logic [TAG_W:0]   count;
   logic [DEPTH-1:0] valid_q;
   logic [DEPTH-1:0] resolved_q;
   logic [DEPTH-1:0] taken_q;

   logic [31:0] head_pc;
   logic        head_pred;
   logic [31:0] head_alt_pc;

   logic commit_now;
   logic flush_now;
   logic alloc_ok;
   logic res_ok;

   assign alloc_tag = tail;
   assign full      = (count == FULL_COUNT);

   // Commit looks only at registered state, so a resolve needs one edge to land.
   assign commit_now = rdy && valid_q[head] && resolved_q[head];
   assign flush_now  = commit_now && (taken_q[head] != head_pred);
   assign alloc_ok   = rdy && alloc_valid && !full && !flush_now;
   assign res_ok     = rdy && res_valid && valid_q[res_tag] && !resolved_q[res_tag] && !flush_now;

   branch_tracker_ram #(
      .DEPTH (DEPTH),
      .TAG_W (TAG_W)
   ) u_ram (
      .clk     (clk),
      .we      (alloc_ok),
      .waddr   (tail),
      .wpc     (alloc_pc),
      .wpred   (alloc_pred),
      .walt_pc (alloc_alt_pc),
      .raddr   (head),
      .rpc     (head_pc),
      .rpred   (head_pred),
      .ralt_pc (head_alt_pc)
   );

   // Pointer, occupancy and per-entry status bits. Because full is based on
   // the pre-edge count, the tail slot can never be the head being retired.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head       <= '0;
         tail       <= '0;
         count      <= '0;
         valid_q    <= '0;
         resolved_q <= '0;
         taken_q    <= '0;
      end else if (rdy) begin
         if (flush_now) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            valid_q    <= '0;
            resolved_q <= '0;
         end else begin
            if (alloc_ok) begin
               valid_q[tail]    <= 1'b1;
               resolved_q[tail] <= 1'b0;
               tail             <= tail + 1'b1;
            end
            if (res_ok) begin
               resolved_q[res_tag] <= 1'b1;
               taken_q[res_tag]    <= res_taken;
            end
            if (commit_now) begin
               valid_q[head] <= 1'b0;
               head          <= head + 1'b1;
            end
            case ({alloc_ok, commit_now})
               2'b10:   count <= count + 1'b1;
               2'b01:   count <= count - 1'b1;
               default: count <= count;
            endcase
         end
      end
   end

   // Registered predictor-update and flush outputs; pulses drop while stalled.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ROB_valid   <= 1'b0;
         commit_pc   <= '0;
         real_result <= 1'b0;
         flush       <= 1'b0;
         flush_pc    <= '0;
      end else if (!rdy) begin
         ROB_valid <= 1'b0;
         flush     <= 1'b0;
      end else begin
         ROB_valid <= commit_now;
         flush     <= flush_now;
         if (commit_now) begin
            commit_pc   <= head_pc;
            real_result <= real_result_of(taken_q[head]);
         end
         if (flush_now) begin
            flush_pc <= head_alt_pc;
         end
      end
   end

endmodule

// File: tb/tb_branch_tracker.sv
// Bench for branch_tracker: expected retirements are queued at allocation
// and matched against every ROB_valid pulse by a negedge monitor.
module tb_branch_tracker;

   localparam int DEPTH = 8;
   localparam int TAG_W = 3;

   typedef struct {
      logic [31:0] pc;
      logic        real_res;
      logic        flush;
      logic [31:0] flush_pc;
   } exp_t;

   typedef struct {
      logic [31:0] pc;
      logic        pred;
      logic [31:0] alt_pc;
      logic        taken;
      logic        exp_real;
   } vec_t;

   logic             clk;
   logic             rst;
   logic             rdy;
   logic             alloc_valid;
   logic [31:0]      alloc_pc;
   logic             alloc_pred;
   logic [31:0]      alloc_alt_pc;
   logic [TAG_W-1:0] alloc_tag;
   logic             full;
   logic             res_valid;
   logic [TAG_W-1:0] res_tag;
   logic             res_taken;
   logic             ROB_valid;
   logic [31:0]      commit_pc;
   logic             real_result;
   logic             flush;
   logic [31:0]      flush_pc;

   exp_t exp_q[$];
   vec_t vecs[3];
   int   total  = 0;
   int   bad    = 0;
   int   pulses = 0;
   int   p0;

   branch_tracker #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .rdy          (rdy),
      .alloc_valid  (alloc_valid),
      .alloc_pc     (alloc_pc),
      .alloc_pred   (alloc_pred),
      .alloc_alt_pc (alloc_alt_pc),
      .alloc_tag    (alloc_tag),
      .full         (full),
      .res_valid    (res_valid),
      .res_tag      (res_tag),
      .res_taken    (res_taken),
      .ROB_valid    (ROB_valid),
      .commit_pc    (commit_pc),
      .real_result  (real_result),
      .flush        (flush),
      .flush_pc     (flush_pc)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every predictor update must match the oldest expected retirement.
   always @(negedge clk) begin
      if (rst && ROB_valid) begin
         pulses++;
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected_pulse: got pc %h expected no pulse", commit_pc);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            checkOutput("commit_pc", commit_pc, e.pc);
            checkOutput("real_result", {31'b0, real_result}, {31'b0, e.real_res});
            checkOutput("flush", {31'b0, flush}, {31'b0, e.flush});
            if (e.flush) checkOutput("flush_pc", flush_pc, e.flush_pc);
         end
      end else if (rst && flush) begin
         total++;
         bad++;
         $display("[TB] FAIL lone_flush: got flush=1 expected 0 without ROB_valid");
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      rst = 1'b0;
      exp_q.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      #2 rst = 1'b1;
   endtask

   task automatic applyStimulus(input logic [31:0] pc, input logic pred, input logic [31:0] alt,
                                input logic [TAG_W-1:0] exp_tag);
      checkOutput("alloc_tag", {29'b0, alloc_tag}, {29'b0, exp_tag});
      alloc_valid  = 1'b1;
      alloc_pc     = pc;
      alloc_pred   = pred;
      alloc_alt_pc = alt;
      tick();
      alloc_valid  = 1'b0;
   endtask

   task automatic resolveTag(input logic [TAG_W-1:0] tag, input logic taken);
      res_valid = 1'b1;
      res_tag   = tag;
      res_taken = taken;
      tick();
      res_valid = 1'b0;
   endtask

   task automatic pushExp(input logic [31:0] pc, input logic rr, input logic fl, input logic [31:0] fpc);
      exp_t e;
      e.pc       = pc;
      e.real_res = rr;
      e.flush    = fl;
      e.flush_pc = fpc;
      exp_q.push_back(e);
   endtask

   task automatic waitDrain(input int budget);
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         #1;
         if (exp_q.size() == 0) break;
      end
      checkOutput("drain", exp_q.size(), 0);
   endtask

   initial begin
      rst = 1'b0;
      rdy = 1'b1;
      alloc_valid = 1'b0;
      alloc_pc = '0;
      alloc_pred = 1'b0;
      alloc_alt_pc = '0;
      res_valid = 1'b0;
      res_tag = '0;
      res_taken = 1'b0;

      vecs[0] = '{pc: 32'h100, pred: 1'b1, alt_pc: 32'h200, taken: 1'b1, exp_real: 1'b0};
      vecs[1] = '{pc: 32'h104, pred: 1'b1, alt_pc: 32'h204, taken: 1'b1, exp_real: 1'b0};
      vecs[2] = '{pc: 32'h108, pred: 1'b1, alt_pc: 32'h208, taken: 1'b1, exp_real: 1'b0};

      #12;
      checkOutput("rst_ROB_valid", {31'b0, ROB_valid}, 0);
      checkOutput("rst_flush", {31'b0, flush}, 0);
      checkOutput("rst_full", {31'b0, full}, 0);
      checkOutput("rst_commit_pc", commit_pc, 0);
      doReset();

      // Mid-operation reset with three live entries and a pulse in flight.
      applyStimulus(32'h010, 1'b1, 32'h020, 3'd0);
      applyStimulus(32'h014, 1'b1, 32'h024, 3'd1);
      applyStimulus(32'h018, 1'b1, 32'h028, 3'd2);
      resolveTag(3'd0, 1'b1);
      tick();
      checkOutput("pre_reset_pulse", {31'b0, ROB_valid}, 1);
      rst = 1'b0;
      #1;
      checkOutput("async_ROB_valid", {31'b0, ROB_valid}, 0);
      checkOutput("async_flush", {31'b0, flush}, 0);
      checkOutput("async_full", {31'b0, full}, 0);
      checkOutput("async_alloc_tag", {29'b0, alloc_tag}, 0);
      p0 = pulses;
      @(negedge clk);
      #2 rst = 1'b1;
      repeat (5) tick();
      checkOutput("post_reset_pulses", pulses, p0);

      // In-order correct predictions from the vector table.
      doReset();
      for (int i = 0; i < 3; i++) begin
         applyStimulus(vecs[i].pc, vecs[i].pred, vecs[i].alt_pc, 3'(i));
         pushExp(vecs[i].pc, vecs[i].exp_real, 1'b0, 32'h0);
      end
      for (int i = 0; i < 3; i++) resolveTag(3'(i), vecs[i].taken);
      waitDrain(10);

      // Out-of-order resolution: nothing retires until the head resolves.
      doReset();
      applyStimulus(32'h200, 1'b0, 32'h280, 3'd0);
      applyStimulus(32'h204, 1'b0, 32'h284, 3'd1);
      pushExp(32'h200, 1'b1, 1'b0, 32'h0);
      pushExp(32'h204, 1'b1, 1'b0, 32'h0);
      p0 = pulses;
      resolveTag(3'd1, 1'b0);
      tick();
      @(negedge clk);
      #1;
      checkOutput("ooo_no_pulse", pulses, p0);
      resolveTag(3'd0, 1'b0);
      @(negedge clk);
      #1;
      checkOutput("ooo_resolve_latency", pulses, p0);
      tick();
      @(negedge clk);
      #1;
      checkOutput("ooo_first", pulses, p0 + 1);
      tick();
      @(negedge clk);
      #1;
      checkOutput("ooo_second", pulses, p0 + 2);

      // Mispredict: flush with corrected PC, younger entry and same-cycle alloc discarded.
      doReset();
      applyStimulus(32'h300, 1'b1, 32'h304, 3'd0);
      applyStimulus(32'h310, 1'b1, 32'h314, 3'd1);
      pushExp(32'h300, 1'b1, 1'b1, 32'h304);
      resolveTag(3'd0, 1'b0);
      alloc_valid = 1'b1;
      alloc_pc    = 32'h400;
      alloc_pred  = 1'b0;
      tick();
      alloc_valid = 1'b0;
      checkOutput("mp_flush", {31'b0, flush}, 1);
      checkOutput("mp_tag_after", {29'b0, alloc_tag}, 0);
      resolveTag(3'd1, 1'b1);
      repeat (3) tick();
      checkOutput("mp_drain", exp_q.size(), 0);
      applyStimulus(32'h500, 1'b0, 32'h504, 3'd0);
      pushExp(32'h500, 1'b1, 1'b0, 32'h0);
      resolveTag(3'd0, 1'b0);
      waitDrain(6);

      // Full and wrap-around.
      doReset();
      for (int i = 0; i < DEPTH; i++) begin
         applyStimulus(32'h600 + 32'(4 * i), 1'b1, 32'h900, 3'(i));
         pushExp(32'h600 + 32'(4 * i), 1'b0, 1'b0, 32'h0);
      end
      checkOutput("full_set", {31'b0, full}, 1);
      applyStimulus(32'h700, 1'b1, 32'h900, 3'd0);
      resolveTag(3'd0, 1'b1);
      tick();
      checkOutput("full_clear", {31'b0, full}, 0);
      applyStimulus(32'h640, 1'b1, 32'h900, 3'd0);
      pushExp(32'h640, 1'b0, 1'b0, 32'h0);
      for (int i = 1; i < DEPTH; i++) resolveTag(3'(i), 1'b1);
      resolveTag(3'd0, 1'b1);
      waitDrain(20);

      // rdy gating holds a resolved head until enabled again.
      doReset();
      applyStimulus(32'h800, 1'b1, 32'h880, 3'd0);
      pushExp(32'h800, 1'b0, 1'b0, 32'h0);
      resolveTag(3'd0, 1'b1);
      rdy = 1'b0;
      p0 = pulses;
      repeat (4) tick();
      @(negedge clk);
      #1;
      checkOutput("rdy_hold", pulses, p0);
      rdy = 1'b1;
      tick();
      checkOutput("rdy_release", {31'b0, ROB_valid}, 1);
      waitDrain(4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
